// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked ALU pipeline:
//   - opcode map (OP_ADD .. OP_NOR)
//   - FSM state encoding of the top-level controller
//   - res_width(): result width for a given operand width (2*WIDTH)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    function automatic int res_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/alu_hs_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_hs_pipe_if
// Operand/result bus of alu_hs_pipe.
//   in1, in2, opcode, in_valid  : operand side, driven by the source
//   in_ready                    : driven by the ALU
//   out, flags, out_valid       : result side, driven by the ALU
//   out_ready                   : driven by the consumer
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. The sender holds its payload stable while valid is 1
// and ready is 0; ready may depend combinationally on the other side.
// modport master = source/consumer side, modport slave = the ALU.
// ---------------------------------------------------------------------------
interface alu_hs_pipe_if #(parameter int WIDTH = 8);
    import alu_pkg::*;

    localparam int RW = res_width(WIDTH);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       opcode;
    logic             in_valid;
    logic             in_ready;
    logic [RW-1:0]    out;
    logic             out_valid;
    logic             out_ready;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_err;

    modport master (
        output in1, in2, opcode, in_valid, out_ready,
        input  in_ready, out, out_valid, flag_zero, flag_carry, flag_err
    );

    modport slave (
        input  in1, in2, opcode, in_valid, out_ready,
        output in_ready, out, out_valid, flag_zero, flag_carry, flag_err
    );

endinterface

// File: rtl/alu_div_iter.sv
// ---------------------------------------------------------------------------
// alu_div_iter
// Iterative restoring divider, one quotient bit per clock.
//   clock, reset        : clock, async active-low reset
//   start               : load dividend/divisor and begin WIDTH steps
//   dividend, divisor   : operands (divisor must be non-zero)
//   done                : high during the final step
//   quotient, remainder : outputs of the current step; final when done=1
// The outputs are the next-step values so the caller can register the
// final result on the same edge the last step completes.
// ---------------------------------------------------------------------------
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract. Since r_r < d_r, a negative trial shows up as bit WIDTH set.
    always_comb begin
        partial = {r_r, q_r[WIDTH-1]};
        trial   = partial - {1'b0, d_r};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            r_next = partial[WIDTH-1:0];
            q_next = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            q_r <= q_next;
            r_r <= r_next;
        end
    end

    assign done      = (cnt == CW'(1));
    assign quotient  = q_next;
    assign remainder = r_next;

endmodule

// File: rtl/alu_hs_pipe.sv
// ---------------------------------------------------------------------------
// alu_hs_pipe
// WIDTH-bit ALU with valid/ready handshakes and a 2*WIDTH-bit registered
// result. Single-cycle ops (and divide by zero) produce a result the cycle
// after acceptance; division runs iteratively for WIDTH+1 cycles.
//   clock     : rising-edge clock
//   reset     : async active-low reset
//   bus       : alu_hs_pipe_if slave (operands, result, flags, handshakes)
//   dbg_state : current controller state (IDLE/DIV/HOLD)
// ---------------------------------------------------------------------------
module alu_hs_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    alu_hs_pipe_if.slave   bus,
    output alu_state_t     dbg_state
);

    localparam int RW = res_width(WIDTH);

    alu_state_t       state;
    logic             started;
    logic             accept;
    logic             drain;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [RW-1:0]    op_a;
    logic [RW-1:0]    op_b;
    logic [RW-1:0]    alu_res;
    logic             alu_carry;
    logic             alu_err;
    logic [RW-1:0]    out_r;
    logic             out_valid_r;
    logic             zero_r;
    logic             carry_r;
    logic             err_r;

    assign op_a = {{WIDTH{1'b0}}, bus.in1};
    assign op_b = {{WIDTH{1'b0}}, bus.in2};

    // 'started' keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = started && (state == ST_IDLE) && (!out_valid_r || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = out_valid_r && bus.out_ready;
    assign div_start    = accept && (bus.opcode == OP_DIV) && (bus.in2 != '0);

    // Single-cycle result. The OP_DIV entry is the divide-by-zero response;
    // a non-zero divisor takes the iterative path instead.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_res   = op_a + op_b;
                alu_carry = alu_res[WIDTH];
            end
            OP_SUB: begin
                alu_res   = op_a - op_b;
                alu_carry = (bus.in1 < bus.in2);
            end
            OP_MUL:  alu_res = op_a * op_b;
            OP_DIV: begin
                alu_res = {bus.in1, {WIDTH{1'b1}}};
                alu_err = 1'b1;
            end
            OP_OR:   alu_res = {{WIDTH{1'b0}}, bus.in1 | bus.in2};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, bus.in1 & bus.in2};
            OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(bus.in1 & bus.in2)};
            OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(bus.in1 | bus.in2)};
            default: alu_res = '0;
        endcase
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (bus.in1),
        .divisor   (bus.in2),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            started     <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            started <= 1'b1;
            // A load below overrides this, giving drain+accept on one edge.
            if (drain) out_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (div_start) begin
                            state <= ST_DIV;
                        end else begin
                            out_r       <= alu_res;
                            zero_r      <= (alu_res == '0);
                            carry_r     <= alu_carry;
                            err_r       <= alu_err;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        out_r       <= {div_r, div_q};
                        zero_r      <= ({div_r, div_q} == '0);
                        carry_r     <= 1'b0;
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (drain) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out        = out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.flag_zero  = zero_r;
    assign bus.flag_carry = carry_r;
    assign bus.flag_err   = err_r;
    assign dbg_state      = state;

endmodule

// File: tb/tb_alu_hs_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_hs_pipe
// Directed bench for alu_hs_pipe (WIDTH=8): vector table of single-cycle
// ops, iterative divisions, backpressure with drain+accept, and reset in
// the middle of a division. Results are also matched in order against an
// expected queue by a monitor.
// ---------------------------------------------------------------------------
module tb_alu_hs_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int RW    = 2 * WIDTH;

    typedef logic [RW+2:0] res_t;   // {err, carry, zero, out}

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RW-1:0]    exp_out;
        logic             ez;
        logic             ec;
        logic             ee;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    alu_hs_pipe_if #(.WIDTH(WIDTH)) bus ();
    alu_state_t dbg_state;

    alu_hs_pipe #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    vec_t vecs[18];

    function automatic res_t pk(input logic e, input logic c, input logic z,
                                input logic [RW-1:0] o);
        return {e, c, z, o};
    endfunction

    function automatic res_t got();
        return {bus.flag_err, bus.flag_carry, bus.flag_zero, bus.out};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called and returns at negedge+1; returns one cycle after the accept edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output int waited);
        waited       = 0;
        bus.opcode   = op;
        bus.in1      = a;
        bus.in2      = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clock); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", waited);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clock);
            @(negedge clock); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic div_seq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [RW-1:0] exp);
        int w;
        int lat;
        exp_q.push_back(pk(1'b0, 1'b0, exp == '0, exp));
        send(OP_DIV, a, b, w);
        check("div_state", dbg_state, ST_DIV);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check("div_in_ready_low", bus.in_ready, 1'b0);
            @(negedge clock); #1;
            lat++;
        end
        check("div_in_ready_hold", bus.in_ready, 1'b0);
        check("div_latency", lat, WIDTH + 1);
        check("div_result", got(), pk(1'b0, 1'b0, exp == '0, exp));
        @(negedge clock); #1;
        check("div_back_idle", bus.in_ready, 1'b1);
    endtask

    // ---------------- scoreboard monitor ----------------
    // Every result handed over (out_valid && out_ready) must match the queue head.
    initial begin
        forever begin
            @(negedge clock); #2;
            if (reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h with no result outstanding", got());
                end else begin
                    check("sb_result", got(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int   w;
        int   seen;
        res_t held;

        vecs[0]  = '{OP_ADD,  8'd200,  8'd100,  16'h012C, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADD,  8'd0,    8'd0,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD,  8'h7F,   8'h01,   16'h0080, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB,  8'd3,    8'd5,    16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_SUB,  8'd9,    8'd9,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_SUB,  8'd200,  8'd55,   16'h0091, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_MUL,  8'd255,  8'd255,  16'hFE01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_MUL,  8'd12,   8'd0,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{OP_MUL,  8'd16,   8'd16,   16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_DIV,  8'd13,   8'd0,    16'h0DFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{OP_DIV,  8'd0,    8'd0,    16'h00FF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_OR,   8'h0F,   8'hF0,   16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_AND,  8'hAA,   8'h0F,   16'h000A, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_AND,  8'hAA,   8'h55,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{OP_NAND, 8'hAA,   8'h0F,   16'h00F5, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{OP_NAND, 8'hFF,   8'hFF,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{OP_NOR,  8'h00,   8'h00,   16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{OP_NOR,  8'h0F,   8'h30,   16'h00C0, 1'b0, 1'b0, 1'b0};

        bus.in1       = '0;
        bus.in2       = '0;
        bus.opcode    = OP_ADD;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_out", bus.out, 16'h0000);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_flags", {bus.flag_err, bus.flag_carry, bus.flag_zero}, 3'b000);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b1;
        @(negedge clock); #1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // table: latency 1, one result per cycle with out_ready=1
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(pk(vecs[i].ee, vecs[i].ec, vecs[i].ez, vecs[i].exp_out));
            send(vecs[i].op, vecs[i].a, vecs[i].b, w);
            if (i > 0) check("vec_no_wait", w, 0);
            check("vec_valid", bus.out_valid, 1'b1);
            check("vec_result", got(), pk(vecs[i].ee, vecs[i].ec, vecs[i].ez, vecs[i].exp_out));
        end
        @(negedge clock); #1;
        check("valid_one_cycle", bus.out_valid, 1'b0);

        // iterative division
        div_seq(8'd200, 8'd7,  16'h041C);
        div_seq(8'd255, 8'd16, 16'h0F0F);
        div_seq(8'd5,   8'd9,  16'h0500);
        div_seq(8'd0,   8'd3,  16'h0000);

        // backpressure, then drain and accept on the same edge
        bus.out_ready = 1'b0;
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 16'h0003));
        send(OP_ADD, 8'd1, 8'd2, w);
        held         = got();
        bus.opcode   = OP_OR;
        bus.in1      = 8'h0F;
        bus.in2      = 8'hF0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            check("bp_hold", got(), pk(1'b0, 1'b0, 1'b0, 16'h0003));
            check("bp_stable", got(), held);
            check("bp_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            @(negedge clock); #1;
        end
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 16'h00FF));
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_rise", bus.in_ready, 1'b1);
        @(posedge clock);
        @(negedge clock); #1;
        bus.in_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1'b1);
        check("bp_next_result", got(), pk(1'b0, 1'b0, 1'b0, 16'h00FF));

        // reset in the middle of a division: no result may ever appear
        send(OP_DIV, 8'd200, 8'd7, w);
        repeat (3) begin
            @(negedge clock); #1;
        end
        check("mid_state", dbg_state, ST_DIV);
        reset = 1'b0;
        #1;
        check("mid_rst_out", bus.out, 16'h0000);
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_flags", {bus.flag_err, bus.flag_carry, bus.flag_zero}, 3'b000);
        check("mid_rst_state", dbg_state, ST_IDLE);
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        check("mid_in_ready", bus.in_ready, 1'b1);
        seen = 0;
        repeat (15) begin
            @(negedge clock); #1;
            if (bus.out_valid) seen++;
        end
        check("mid_no_stale", seen, 0);
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 16'h0007));
        send(OP_SUB, 8'd10, 8'd3, w);
        check("post_rst_result", got(), pk(1'b0, 1'b0, 1'b0, 16'h0007));

        repeat (3) @(negedge clock);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_hs_pipe.md
Name: alu_hs_pipe

Overview:
Parametrised successor to the 4-bit two-unit ALU: one WIDTH-bit operand datapath with the same 3-bit opcode map and a 2*WIDTH-bit registered result.
- Adds a valid/ready handshake on input and output, status flags, and a defined divide-by-zero response.
- Division is multi-cycle and iterative.
- Sits between an operand source (sequencer or bus adapter) and a result consumer; both sides may stall.

Parameters:
WIDTH, 8, operand width in bits (min 2); result width is 2*WIDTH.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in1  input  WIDTH  operand A (unsigned).
in2  input  WIDTH  operand B (unsigned).
opcode  input  3  operation select: 000 add, 001 sub, 010 mul, 011 div, 100 or, 101 and, 110 nand, 111 nor.
in_valid  input  1  operands/opcode valid.
in_ready  output  1  block can accept an operation this cycle.
out  output  2*WIDTH  result.
out_valid  output  1  out and flags valid.
out_ready  input  1  consumer accepts result.
flag_zero  output  1  out == 0.
flag_carry  output  1  add: carry out of bit WIDTH-1; sub: borrow (in1 < in2); 0 for all other ops.
flag_err  output  1  divide by zero.

Behaviour:
- Reset (async, reset==0):
  - out=0, all flags=0, out_valid=0.
  - FSM=IDLE; divider state cleared.
  - in_ready=1 from the first clock edge after reset release.
  - Reset mid-division abandons the operation; no result is ever produced for it.
- Accept: in_valid && in_ready at a rising edge; operands and opcode are captured.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A result drain and a new accept may occur on the same edge.
- FSM states: IDLE, DIV, HOLD.
  - IDLE, accept of a non-div op, or div with in2==0: result registered that edge; out_valid=1 next cycle (latency 1); remain IDLE.
  - IDLE, accept of div with in2!=0: go to DIV; load the iteration counter with WIDTH.
  - DIV: one restoring-division step per cycle; counter decrements. When the counter reaches 0, register the result, set out_valid, go to HOLD. Total latency accept->out_valid is WIDTH+1 cycles.
  - HOLD: wait for out_ready, then go to IDLE. in_ready stays 0 during DIV and HOLD.
- Output hold: while out_valid && !out_ready, out and flags are stable. out_valid drops the cycle after handshake unless a new single-cycle result is loaded on the same edge.
- Arithmetic (all modulo 2^(2*WIDTH); operands zero-extended):
  - add: in1+in2.
  - sub: in1-in2, wraps (e.g. 3-5 with WIDTH=8 gives 0xFFFE).
  - mul: full in1*in2 product.
  - div: out = {remainder, quotient}, remainder in upper WIDTH bits.
  - div by zero: out = {in1, all-ones}, flag_err=1, single cycle, never enters DIV.
- Logic ops: bitwise on WIDTH bits; the upper WIDTH bits of out are 0 (nand/nor do not fill the upper half).
- No X is ever driven on out in any opcode or state.
- flag_zero is computed from the final 2*WIDTH result.
- Inputs are ignored when !in_valid, or when in_valid is high while in_ready is 0; the source must hold them.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_NOR);
  - FSM state encoding (IDLE/DIV/HOLD);
  - helper function for result width (2*WIDTH).
- Sub-module alu_div_iter:
  - restoring divider; WIDTH-cycle start/done interface;
  - quotient/remainder registers and iteration counter;
  - instantiated once by alu_hs_pipe.
- Single-cycle ops stay inline in the top.

Test Plan:
1. WIDTH=8, add 200+100, out_ready=1 -> next cycle out=0x012C, flag_carry=1, flag_zero=0, out_valid 1 cycle.
2. sub 3-5 -> out=0xFFFE, flag_carry=1; sub 9-9 -> out=0x0000, flag_zero=1, flag_carry=0.
3. mul 255*255 -> out=0xFE01 at latency 1. Back-to-back ops with out_ready=1 yield one result per cycle.
4. div 200/7 -> in_ready=0 for 9 cycles; out_valid at accept+9; out=0x041C (rem 4, quot 28), flag_err=0. div 13/0 -> out=0x0DFF, flag_err=1 at latency 1.
5. Backpressure: result pending, out_ready=0 for 3 cycles -> out/flags stable, in_ready=0. Raise out_ready while in_valid (OR 0x0F|0xF0) -> drain and accept same edge; next out=0x00FF.
6. Assert reset for 1 cycle at cycle 4 of a div -> out=0, out_valid=0, flags=0 immediately. After release, in_ready=1 and no stale result appears.
